// File: rtl/port_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// port_xfer_ctrl
//
// Purpose:
//   Controller-side sequencer for a bidirectional port bundle. It turns one
//   single-word read or write request into a timed bus cycle:
//     IDLE -> [TURN] -> [SETUP] -> STROBE -> [HOLD] -> IDLE
//   Bracketed phases are skipped when their length parameter is zero. TURN is
//   only entered when the requested direction differs from the direction of
//   the previous transfer. During TURN dir_to_port is 0, so the FPGA and the
//   external device never drive the bus at the same time.
//
// Ports:
//   clk, reset     : single clock, synchronous active-high reset
//   req_valid/ready: request handshake. A request transfers on a cycle where
//                    req_valid and req_ready are both 1. req_ready is 1 only
//                    in IDLE, so one transfer is in flight at a time.
//                    req_write/req_wdata are sampled only on that cycle.
//   req_write      : 1 = write, 0 = read
//   req_wdata      : write data
//   rsp_valid      : one-cycle pulse on the cycle after the last STROBE cycle
//                    of a read (never for writes)
//   rsp_rdata      : last read data, held until the next read completes
//   dir_to_port    : 1 = FPGA drives the port
//   to_port        : data driven to the port
//   from_port      : data sampled from the port
//   port_strobe    : bus-cycle strobe to the external device
//   port_wait      : only with PORT_XFER_WAIT_EN; stretches the last STROBE
//                    cycle while high
//
// Configuration macro:
//   PORT_XFER_WAIT_EN - adds port_wait. Without it, the strobe length is fixed
//                       at STROBE_CYCLES.
//
// All outputs are registered. The values are computed from the next state, so
// the output seen in a cycle matches the state of that same cycle.
// -----------------------------------------------------------------------------
module port_xfer_ctrl #(
   parameter int WIDTH         = 8,
   parameter int TURN_CYCLES   = 2,
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 2,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             dir_to_port,
   output logic [WIDTH-1:0] to_port,
   input  logic [WIDTH-1:0] from_port,
   output logic             port_strobe
`ifdef PORT_XFER_WAIT_EN
   ,
   input  logic             port_wait
`endif
);

   // Phase counter sized for the longest phase.
   localparam int MAX_TS = (TURN_CYCLES > SETUP_CYCLES) ? TURN_CYCLES : SETUP_CYCLES;
   localparam int MAX_SH = (STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES;
   localparam int MAX_P  = (MAX_TS > MAX_SH) ? MAX_TS : MAX_SH;
   localparam int CNT_W  = (MAX_P < 1) ? 1 : $clog2(MAX_P + 1);

   // The counter is loaded with length-1 on phase entry. The phase ends on
   // the cycle where the count reads zero. Zero-length phases are never
   // entered, so their load value is irrelevant.
   localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'((TURN_CYCLES   > 0) ? TURN_CYCLES   - 1 : 0);
   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'((SETUP_CYCLES  > 0) ? SETUP_CYCLES  - 1 : 0);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'((STROBE_CYCLES > 0) ? STROBE_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_CYCLES   > 0) ? HOLD_CYCLES   - 1 : 0);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_TURN   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_STROBE = 3'd3,
      ST_HOLD   = 3'd4
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_wr;
   logic [WIDTH-1:0]   r_wdata;
   logic               r_last_dir;
   logic               r_req_ready;
   logic               r_dir;
   logic [WIDTH-1:0]   r_to_port;
   logic               r_strobe;
   logic               r_rsp_valid;
   logic [WIDTH-1:0]   r_rsp_rdata;

   state_t             w_state_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_wr_nxt;
   logic [WIDTH-1:0]   w_wdata_nxt;
   logic               w_last_dir_nxt;
   logic               w_rsp_fire;
   logic               w_ready_nxt;
   logic               w_dir_nxt;
   logic [WIDTH-1:0]   w_to_port_nxt;
   logic               w_strobe_nxt;
   logic               w_accept;
   logic               w_cnt_zero;
   logic               w_strobe_go;

   // r_req_ready, not the state, gates acceptance. On the first cycle after
   // reset release the state is IDLE but req_ready is still 0.
   assign w_accept   = r_req_ready & req_valid;
   assign w_cnt_zero = (r_cnt == '0);

`ifdef PORT_XFER_WAIT_EN
   assign w_strobe_go = w_cnt_zero & ~port_wait;
`else
   assign w_strobe_go = w_cnt_zero;
`endif

   // Next-state, counter and transaction-latch logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_wr_nxt       = r_wr;
      w_wdata_nxt    = r_wdata;
      w_last_dir_nxt = r_last_dir;
      w_rsp_fire     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_wr_nxt    = req_write;
               w_wdata_nxt = req_wdata;
               if ((req_write != r_last_dir) && (TURN_CYCLES > 0)) begin
                  w_state_nxt = ST_TURN;
                  w_cnt_nxt   = TURN_LD;
               end else if (SETUP_CYCLES > 0) begin
                  w_state_nxt = ST_SETUP;
                  w_cnt_nxt   = SETUP_LD;
               end else begin
                  w_state_nxt = ST_STROBE;
                  w_cnt_nxt   = STROBE_LD;
               end
            end
         end

         ST_TURN: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (SETUP_CYCLES > 0) begin
               w_state_nxt = ST_SETUP;
               w_cnt_nxt   = SETUP_LD;
            end else begin
               w_state_nxt = ST_STROBE;
               w_cnt_nxt   = STROBE_LD;
            end
         end

         ST_SETUP: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_state_nxt = ST_STROBE;
               w_cnt_nxt   = STROBE_LD;
            end
         end

         ST_STROBE: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (w_strobe_go) begin
               // Last strobe cycle: sample reads, record the bus direction.
               w_last_dir_nxt = r_wr;
               w_rsp_fire     = ~r_wr;
               if (HOLD_CYCLES > 0) begin
                  w_state_nxt = ST_HOLD;
                  w_cnt_nxt   = HOLD_LD;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            // Otherwise the strobe is stretched by port_wait and the count stays at zero.
         end

         ST_HOLD: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Output values for the state that will be current after the next edge.
   always_comb begin
      w_ready_nxt   = 1'b0;
      w_dir_nxt     = 1'b0;
      w_to_port_nxt = '0;
      w_strobe_nxt  = 1'b0;

      case (w_state_nxt)
         ST_IDLE: begin
            w_ready_nxt   = 1'b1;
            w_dir_nxt     = w_last_dir_nxt;
            // Keep driving the last value while parked in the same direction.
            w_to_port_nxt = r_to_port;
         end
         ST_TURN: begin
            w_dir_nxt     = 1'b0;
            w_to_port_nxt = '0;
         end
         ST_SETUP, ST_HOLD: begin
            w_dir_nxt     = w_wr_nxt;
            w_to_port_nxt = w_wr_nxt ? w_wdata_nxt : '0;
         end
         ST_STROBE: begin
            w_dir_nxt     = w_wr_nxt;
            w_to_port_nxt = w_wr_nxt ? w_wdata_nxt : '0;
            w_strobe_nxt  = 1'b1;
         end
         default: begin
            w_ready_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_wr        <= 1'b0;
         r_wdata     <= '0;
         r_last_dir  <= 1'b0;
         r_req_ready <= 1'b0;
         r_dir       <= 1'b0;
         r_to_port   <= '0;
         r_strobe    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_wr        <= w_wr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_last_dir  <= w_last_dir_nxt;
         r_req_ready <= w_ready_nxt;
         r_dir       <= w_dir_nxt;
         r_to_port   <= w_to_port_nxt;
         r_strobe    <= w_strobe_nxt;
         r_rsp_valid <= w_rsp_fire;
         if (w_rsp_fire) begin
            r_rsp_rdata <= from_port;
         end
      end
   end

   assign req_ready   = r_req_ready;
   assign dir_to_port = r_dir;
   assign to_port     = r_to_port;
   assign port_strobe = r_strobe;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;

endmodule

// File: tb/tb_port_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_port_xfer_ctrl
//
// Two instances are simulated:
//   u_dut_a : default timing (TURN=2, SETUP=1, STROBE=2, HOLD=1)
//   u_dut_b : TURN=0, SETUP=0, STROBE=2, HOLD=0
//
// Driver tasks push the hand-derived output of every cycle into a queue per
// instance. Expected read data goes into a separate response queue. Monitors
// on the falling edge pop and compare these queues, independently of the
// drivers.
// -----------------------------------------------------------------------------
module tb_port_xfer_ctrl;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A signals
   logic         reset_a;
   logic         req_valid_a;
   logic         req_ready_a;
   logic         req_write_a;
   logic [W-1:0] req_wdata_a;
   logic         rsp_valid_a;
   logic [W-1:0] rsp_rdata_a;
   logic         dir_a;
   logic [W-1:0] to_a;
   logic [W-1:0] from_a;
   logic         strobe_a;
   logic         wait_a;

   // Instance B signals
   logic         reset_b;
   logic         req_valid_b;
   logic         req_ready_b;
   logic         req_write_b;
   logic [W-1:0] req_wdata_b;
   logic         rsp_valid_b;
   logic [W-1:0] rsp_rdata_b;
   logic         dir_b;
   logic [W-1:0] to_b;
   logic [W-1:0] from_b;
   logic         strobe_b;

   port_xfer_ctrl #(
      .WIDTH(W), .TURN_CYCLES(2), .SETUP_CYCLES(1), .STROBE_CYCLES(2), .HOLD_CYCLES(1)
   ) u_dut_a (
      .clk(clk), .reset(reset_a),
      .req_valid(req_valid_a), .req_ready(req_ready_a),
      .req_write(req_write_a), .req_wdata(req_wdata_a),
      .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
      .dir_to_port(dir_a), .to_port(to_a), .from_port(from_a),
      .port_strobe(strobe_a)
`ifdef PORT_XFER_WAIT_EN
      , .port_wait(wait_a)
`endif
   );

   port_xfer_ctrl #(
      .WIDTH(W), .TURN_CYCLES(0), .SETUP_CYCLES(0), .STROBE_CYCLES(2), .HOLD_CYCLES(0)
   ) u_dut_b (
      .clk(clk), .reset(reset_b),
      .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_write(req_write_b), .req_wdata(req_wdata_b),
      .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
      .dir_to_port(dir_b), .to_port(to_b), .from_port(from_b),
      .port_strobe(strobe_b)
`ifdef PORT_XFER_WAIT_EN
      , .port_wait(1'b0)
`endif
   );

   // Expected per-cycle outputs. When chk_data is 0, to_port is not compared.
   typedef struct packed {
      logic         ready;
      logic         dir;
      logic         chk_data;
      logic [W-1:0] to_port;
      logic         strobe;
      logic         rsp_valid;
      logic [W-1:0] rdata;
   } rec_t;

   rec_t         exp_a_q[$];
   rec_t         exp_b_q[$];
   logic [W-1:0] exp_rsp_a_q[$];
   logic [W-1:0] exp_rsp_b_q[$];

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W-1:0] cur_rd_a = '0;
   logic [W-1:0] cur_rd_b = '0;
   logic         pend_rv_b = 1'b0;

   // ---------------- clock helpers / drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic rdy, input logic dir, input logic chk,
                         input logic [W-1:0] tp, input logic stb, input logic rv,
                         input logic [W-1:0] rd);
      rec_t r;
      r = {rdy, dir, chk, tp, stb, rv, rd};
      exp_a_q.push_back(r);
   endtask

   task automatic push_b(input logic rdy, input logic dir, input logic chk,
                         input logic [W-1:0] tp, input logic stb, input logic rv,
                         input logic [W-1:0] rd);
      rec_t r;
      r = {rdy, dir, chk, tp, stb, rv, rd};
      exp_b_q.push_back(r);
   endtask

   // Busy cycle on A. req_valid stays high with changing data, which the DUT must ignore.
   task automatic busy_tick_a();
      req_write_a = 1'($urandom_range(0, 1));
      req_wdata_a = 8'($urandom_range(0, 255));
      tick();
   endtask

   // One full transfer on A with default timing. It starts in an IDLE cycle
   // and ends after the HOLD cycle.
   task automatic xfer_a(input logic wr, input logic [W-1:0] wd,
                         input logic [W-1:0] rd_val, input logic prev_dir);
      logic [W-1:0] tp;
      tp = wr ? wd : 8'h00;
      push_a(1'b1, prev_dir, 1'b0, 8'h00, 1'b0, 1'b0, cur_rd_a);
      req_valid_a = 1'b1;
      req_write_a = wr;
      req_wdata_a = wd;
      from_a      = ~rd_val;
      tick();
      if (wr != prev_dir) begin
         repeat (2) begin
            push_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, cur_rd_a);
            busy_tick_a();
         end
      end
      push_a(1'b0, wr, 1'b1, tp, 1'b0, 1'b0, cur_rd_a);
      busy_tick_a();
      push_a(1'b0, wr, 1'b1, tp, 1'b1, 1'b0, cur_rd_a);
      busy_tick_a();
      from_a = rd_val;
      push_a(1'b0, wr, 1'b1, tp, 1'b1, 1'b0, cur_rd_a);
      busy_tick_a();
      from_a      = ~rd_val;
      req_valid_a = 1'b0;
      if (!wr) begin
         cur_rd_a = rd_val;
         exp_rsp_a_q.push_back(rd_val);
      end
      push_a(1'b0, wr, 1'b1, tp, 1'b0, !wr, cur_rd_a);
      tick();
   endtask

   // One transfer on B (strobe only). A read's rsp_valid lands in the
   // following IDLE cycle.
   task automatic xfer_b(input logic wr, input logic [W-1:0] wd,
                         input logic [W-1:0] rd_val, input logic prev_dir);
      logic [W-1:0] tp;
      tp = wr ? wd : 8'h00;
      push_b(1'b1, prev_dir, 1'b0, 8'h00, 1'b0, pend_rv_b, cur_rd_b);
      pend_rv_b   = 1'b0;
      req_valid_b = 1'b1;
      req_write_b = wr;
      req_wdata_b = wd;
      from_b      = ~rd_val;
      tick();
      req_valid_b = 1'b0;
      push_b(1'b0, wr, 1'b1, tp, 1'b1, 1'b0, cur_rd_b);
      tick();
      from_b = rd_val;
      push_b(1'b0, wr, 1'b1, tp, 1'b1, 1'b0, cur_rd_b);
      tick();
      from_b = ~rd_val;
      if (!wr) begin
         cur_rd_b  = rd_val;
         pend_rv_b = 1'b1;
         exp_rsp_b_q.push_back(rd_val);
      end
   endtask

   // ---------------- scoreboard ----------------
   function automatic void cmp_rec(input string nm, input rec_t e, input rec_t a);
      logic ok;
      ok = (a.ready === e.ready) && (a.dir === e.dir) && (a.strobe === e.strobe) &&
           (a.rsp_valid === e.rsp_valid) && (a.rdata === e.rdata) &&
           (!e.chk_data || (a.to_port === e.to_port));
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s @%0t: got rdy=%b dir=%b to=%h stb=%b rv=%b rd=%h, required rdy=%b dir=%b to=%h(chk=%b) stb=%b rv=%b rd=%h",
                  nm, $time, a.ready, a.dir, a.to_port, a.strobe, a.rsp_valid, a.rdata,
                  e.ready, e.dir, e.to_port, e.chk_data, e.strobe, e.rsp_valid, e.rdata);
      end
   endfunction

   always @(negedge clk) begin
      rec_t         act;
      logic [W-1:0] er;
      if (exp_a_q.size() > 0) begin
         act = {req_ready_a, dir_a, 1'b0, to_a, strobe_a, rsp_valid_a, rsp_rdata_a};
         cmp_rec("cycle_a", exp_a_q.pop_front(), act);
      end
      if (rsp_valid_a === 1'b1) begin
         n_tests++;
         if (exp_rsp_a_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_a @%0t: unexpected rsp_valid with rdata=%h, required no response", $time, rsp_rdata_a);
         end else begin
            er = exp_rsp_a_q.pop_front();
            if (rsp_rdata_a !== er) begin
               n_fail++;
               $display("FAIL rsp_a @%0t: rdata=%h, required %h", $time, rsp_rdata_a, er);
            end
         end
      end
   end

   always @(negedge clk) begin
      rec_t         act;
      logic [W-1:0] er;
      if (exp_b_q.size() > 0) begin
         act = {req_ready_b, dir_b, 1'b0, to_b, strobe_b, rsp_valid_b, rsp_rdata_b};
         cmp_rec("cycle_b", exp_b_q.pop_front(), act);
      end
      if (rsp_valid_b === 1'b1) begin
         n_tests++;
         if (exp_rsp_b_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_b @%0t: unexpected rsp_valid with rdata=%h, required no response", $time, rsp_rdata_b);
         end else begin
            er = exp_rsp_b_q.pop_front();
            if (rsp_rdata_b !== er) begin
               n_fail++;
               $display("FAIL rsp_b @%0t: rdata=%h, required %h", $time, rsp_rdata_b, er);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset_a = 1'b1; req_valid_a = 1'b0; req_write_a = 1'b0; req_wdata_a = '0;
      from_a  = '0;   wait_a = 1'b0;
      reset_b = 1'b1; req_valid_b = 1'b0; req_write_b = 1'b0; req_wdata_b = '0;
      from_b  = '0;

      // Reset state. req_ready stays 0 through the cycle after release.
      tick();
      push_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
      push_b(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
      tick();
      push_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
      push_b(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
      reset_a = 1'b0;
      reset_b = 1'b0;
      tick();

      // ---- instance A, default timing ----
      xfer_a(1'b1, 8'hA5, 8'h00, 1'b0);   // write with TURN
      xfer_a(1'b0, 8'h00, 8'h3C, 1'b1);   // read after write, strobe 11-12
      xfer_a(1'b1, 8'h5A, 8'h00, 1'b0);   // read -> write TURN
      xfer_a(1'b1, 8'h01, 8'h00, 1'b1);   // back-to-back writes, no TURN
      xfer_a(1'b1, 8'h02, 8'h00, 1'b1);
      xfer_a(1'b0, 8'h00, 8'h96, 1'b1);   // write -> read TURN
      xfer_a(1'b0, 8'h00, 8'h69, 1'b0);   // back-to-back reads, no TURN
      xfer_a(1'b1, 8'hC7, 8'h00, 1'b0);   // leaves last_dir = write

      // Read aborted by reset during its first STROBE cycle.
      push_a(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, cur_rd_a);
      req_valid_a = 1'b1; req_write_a = 1'b0; req_wdata_a = 8'h00; from_a = 8'hEE;
      tick();
      repeat (2) begin
         push_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, cur_rd_a);
         busy_tick_a();
      end
      push_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, cur_rd_a);
      busy_tick_a();
      push_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, cur_rd_a);
      reset_a = 1'b1;
      req_valid_a = 1'b0;
      tick();
      cur_rd_a = 8'h00;
      push_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
      reset_a = 1'b0;
      tick();
      // last_dir is back to read, so the IDLE dir is 0 and the next read has no TURN.
      xfer_a(1'b0, 8'h00, 8'h11, 1'b0);

`ifdef PORT_XFER_WAIT_EN
      // Read whose last strobe cycle is stretched for 3 cycles by port_wait.
      push_a(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, cur_rd_a);
      req_valid_a = 1'b1; req_write_a = 1'b0; from_a = 8'hA1;
      tick();
      req_valid_a = 1'b0;
      push_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, cur_rd_a);
      tick();
      push_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, cur_rd_a);
      tick();
      repeat (3) begin
         wait_a = 1'b1;
         push_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, cur_rd_a);
         tick();
      end
      wait_a = 1'b0;
      from_a = 8'h5E;
      push_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, cur_rd_a);
      tick();
      from_a   = 8'hA1;
      cur_rd_a = 8'h5E;
      exp_rsp_a_q.push_back(8'h5E);
      push_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, cur_rd_a);
      tick();
`endif

      push_a(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, cur_rd_a);
      tick();

      // ---- instance B, zero-length TURN/SETUP/HOLD ----
      push_b(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, cur_rd_b);
      tick();
      xfer_b(1'b1, 8'h81, 8'h00, 1'b0);
      xfer_b(1'b0, 8'h00, 8'h42, 1'b1);
      xfer_b(1'b1, 8'h24, 8'h00, 1'b0);   // accepted in the IDLE cycle that carries rsp_valid
      xfer_b(1'b0, 8'h00, 8'hBD, 1'b1);
      push_b(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, pend_rv_b, cur_rd_b);
      pend_rv_b = 1'b0;
      tick();
      push_b(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, cur_rd_b);
      tick();

      repeat (3) tick();

      // Every expected record and response must have been consumed.
      n_tests++;
      if ((exp_a_q.size() != 0) || (exp_b_q.size() != 0) ||
          (exp_rsp_a_q.size() != 0) || (exp_rsp_b_q.size() != 0)) begin
         n_fail++;
         $display("FAIL drain: left cyc_a=%0d cyc_b=%0d rsp_a=%0d rsp_b=%0d, required all 0",
                  exp_a_q.size(), exp_b_q.size(), exp_rsp_a_q.size(), exp_rsp_b_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
